// File: rtl/fifo_burst_reader_if.sv
// Valid/ready burst stream leaving fifo_burst_reader: data, valid and last flow
// from master to slave, and ready flows back.
interface fifo_burst_reader_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_last;
  logic             m_ready;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/fifo_burst_reader.sv
// Read-side stage behind the synchronous FIFO: absorbs its one-cycle read latency and
// re-emits words as fixed-length bursts. Define FIFO_BURST_READER_STATS_EN for beat/burst counters.
module fifo_burst_reader #(
  parameter int WIDTH     = 64,
  parameter int BURST_LEN = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                fifo_empty,
  input  logic [WIDTH-1:0]    fifo_dout,
  output logic                fifo_ren,
  fifo_burst_reader_if.master m_if,
  output logic                busy
`ifdef FIFO_BURST_READER_STATS_EN
  ,
  output logic [31:0]         beat_count,
  output logic [31:0]         burst_count
`endif
);

  localparam int CNT_W = $clog2(BURST_LEN);
  localparam int SUM_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] buf0_q, buf0_d;
  logic [WIDTH-1:0] buf1_q, buf1_d;

  logic             permit;
  logic             valid;
  logic             last;
  logic             pop;
  logic [SUM_W-1:0] pending;
  logic [SUM_W-1:0] need;

  assign valid   = (occ_q != 2'd0);
  assign last    = valid && (cnt_q == LAST_BEAT);
  assign pop     = valid && m_if.m_ready;
  // pending counts words buffered plus the one possibly returning from the FIFO
  assign pending = SUM_W'(occ_q) + SUM_W'(inflight_q);
  assign need    = SUM_W'(BURST_LEN) - SUM_W'(cnt_q);

  assign m_if.m_data  = buf0_q;
  assign m_if.m_valid = valid;
  assign m_if.m_last  = last;
  assign busy         = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    permit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
        else        state_d = IDLE;
      end
      RUN: begin
        permit = 1'b1;
        if (enable)                                           state_d = RUN;
        else if ((cnt_q == '0) && (pending == SUM_W'(0)))     state_d = IDLE;
        else                                                  state_d = DRAIN;
      end
      DRAIN: begin
        // only fetch what is still missing from the open burst
        permit = (pending < need);
        if (enable)          state_d = RUN;
        else if (pop && last) state_d = IDLE;
        else                  state_d = DRAIN;
      end
      default: begin
        state_d = IDLE;
        permit  = 1'b0;
      end
    endcase
    fifo_ren   = !reset && !fifo_empty && permit && ((pending - SUM_W'(pop)) < SUM_W'(2));
    inflight_d = fifo_ren;
  end

  always_comb begin
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    case ({inflight_q, pop})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) buf0_d = fifo_dout;
        else               buf1_d = fifo_dout;
      end
      2'b01: begin
        occ_d  = occ_q - 2'd1;
        buf0_d = buf1_q;
      end
      2'b11: begin
        // issue rule keeps occ below 2 here; occ=1 simply replaces the head
        if (occ_q == 2'd1) begin
          buf0_d = fifo_dout;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_dout;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
    if (pop) cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CNT_W'(1);
    else     cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

`ifdef FIFO_BURST_READER_STATS_EN
  logic [31:0] beat_count_q, beat_count_d;
  logic [31:0] burst_count_q, burst_count_d;

  always_comb begin
    if (pop) beat_count_d = beat_count_q + 32'd1;
    else     beat_count_d = beat_count_q;
    if (pop && last) burst_count_d = burst_count_q + 32'd1;
    else             burst_count_d = burst_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_count_q  <= 32'd0;
      burst_count_q <= 32'd0;
    end else begin
      beat_count_q  <= beat_count_d;
      burst_count_q <= burst_count_d;
    end
  end

  assign beat_count  = beat_count_q;
  assign burst_count = burst_count_q;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural upstream FIFO plus an ordered word queue and
// beat index as reference; covers latency, backpressure, drain, empty gaps and reset.
module tb_fifo_burst_reader;

  localparam int W  = 64;
  localparam int BL = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         fifo_empty;
  logic [W-1:0] fifo_dout = '0;
  logic         fifo_ren;
  logic         busy;
`ifdef FIFO_BURST_READER_STATS_EN
  logic [31:0]  beat_count;
  logic [31:0]  burst_count;
`endif

  fifo_burst_reader_if #(.WIDTH(W)) s_if ();

  fifo_burst_reader #(.WIDTH(W), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_ren   (fifo_ren),
    .m_if       (s_if),
    .busy       (busy)
`ifdef FIFO_BURST_READER_STATS_EN
    ,
    .beat_count (beat_count),
    .burst_count(burst_count)
`endif
  );

  always #5 clk = ~clk;

  // upstream FIFO: registered read data, one cycle after fifo_ren
  logic [W-1:0] mem [0:63];
  int           wr_ptr = 0;
  int           rd_ptr = 0;
  int           rd_base = 0;
  logic         ren_empty_seen = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_ren) begin
      fifo_dout <= mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
    end
    if (fifo_ren && fifo_empty) ren_empty_seen <= 1'b1;
  end

  logic [W-1:0] exp_q [$];
  int           beat_idx = 0;
  int           checks = 0;
  int           errors = 0;

  task automatic fifo_write(input logic [W-1:0] d);
    mem[wr_ptr % 64] = d;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(d);
  endtask

  // reset asserted immediately for one rising edge; the FIFO shares the reset
  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    s_if.m_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    wr_ptr = rd_ptr;
    rd_base = rd_ptr;
    exp_q.delete();
    beat_idx = 0;
  endtask

  // one cycle: sample outputs and reference at negedge, drive ready, account the pop
  task automatic tick(input logic rdy, output logic v, output logic [W-1:0] d, output logic l,
                      output logic [W-1:0] ed, output logic el, output logic r);
    @(negedge clk);
    v  = s_if.m_valid;
    d  = s_if.m_data;
    l  = s_if.m_last;
    r  = fifo_ren;
    ed = (exp_q.size() > 0) ? exp_q[0] : {W{1'bx}};
    el = ((beat_idx % BL) == BL - 1);
    s_if.m_ready = rdy;
    if (v && rdy) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      beat_idx = beat_idx + 1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    s_if.m_ready = 1'b1;
    fifo_write(64'h0000_0000_0000_00A5);
    repeat (2) @(negedge clk);
    checks++;
    if ({s_if.m_valid, s_if.m_last, busy, fifo_ren} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got valid/last/busy/ren=%b expected 0000",
               {s_if.m_valid, s_if.m_last, busy, fifo_ren});
    end
    checks++;
    if (s_if.m_data !== {W{1'b0}}) begin
      errors++;
      $display("FAIL reset_data got %h expected 0", s_if.m_data);
    end
`ifdef FIFO_BURST_READER_STATS_EN
    checks++;
    if (beat_count !== 32'd0 || burst_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_stats got %0d/%0d expected 0/0", beat_count, burst_count);
    end
`endif
    do_reset();
  endtask

  task automatic test_stream();
    logic v, l, el, r;
    logic [W-1:0] d, ed;
    int first_ren, first_valid, last_valid, nbeats;
    do_reset();
    for (int i = 0; i < 8; i++) fifo_write(W'(32'h10 + i));
    s_if.m_ready = 1'b1;
    enable = 1'b1;
    first_ren = -1; first_valid = -1; last_valid = -1; nbeats = 0;
    for (int c = 0; c < 30; c++) begin
      tick(1'b1, v, d, l, ed, el, r);
      if (r && first_ren < 0) first_ren = c;
      if (v) begin
        checks++;
        if (d !== ed || l !== el) begin
          errors++;
          $display("FAIL stream_beat got %h last=%b expected %h last=%b", d, l, ed, el);
        end
        if (first_valid < 0) first_valid = c;
        last_valid = c;
        nbeats++;
      end
    end
    checks++;
    if (first_ren < 0 || first_valid - first_ren != 2) begin
      errors++;
      $display("FAIL stream_latency got ren@%0d valid@%0d expected gap 2", first_ren, first_valid);
    end
    checks++;
    if (nbeats != 8 || last_valid - first_valid != 7) begin
      errors++;
      $display("FAIL stream_rate got %0d beats over %0d cycles expected 8 over 8",
               nbeats, last_valid - first_valid + 1);
    end
  endtask

  task automatic test_backpressure();
    logic v, l, el, r, rdy, prev_stall, pl;
    logic [W-1:0] d, ed, pd;
    logic [3:0] pat;
    int n, c, outstanding;
    pat = 4'b1001;
    for (int pass = 0; pass < 3; pass++) begin
      do_reset();
      n = (pass == 0) ? 8 : int'($urandom_range(6, 20));
      for (int i = 0; i < n; i++) fifo_write({$urandom, $urandom});
      enable = 1'b1;
      prev_stall = 1'b0; pd = '0; pl = 1'b0;
      c = 0;
      while (c < 400 && beat_idx < n) begin
        rdy = (pass == 0) ? pat[3 - (c % 4)] : 1'($urandom_range(0, 1));
        tick(rdy, v, d, l, ed, el, r);
        c++;
        outstanding = (rd_ptr - rd_base) - beat_idx + ((v && rdy) ? 1 : 0);
        checks++;
        if (outstanding > 2) begin
          errors++;
          $display("FAIL bp_occupancy got %0d expected <= 2", outstanding);
        end
        if (prev_stall) begin
          checks++;
          if (!v || d !== pd || l !== pl) begin
            errors++;
            $display("FAIL bp_hold got v=%b %h last=%b expected v=1 %h last=%b", v, d, l, pd, pl);
          end
        end
        if (v) begin
          checks++;
          if (d !== ed || l !== el) begin
            errors++;
            $display("FAIL bp_beat got %h last=%b expected %h last=%b", d, l, ed, el);
          end
        end
        prev_stall = v && !rdy;
        pd = d;
        pl = l;
      end
      tick(1'b1, v, d, l, ed, el, r);
      checks++;
      if (beat_idx != n || v !== 1'b0 || exp_q.size() != 0) begin
        errors++;
        $display("FAIL bp_complete got %0d beats valid=%b expected %0d beats valid=0", beat_idx, v, n);
      end
    end
  endtask

  task automatic test_drain();
    logic v, l, el, r;
    logic [W-1:0] d, ed;
    int exp_total;
    do_reset();
    for (int i = 0; i < 10; i++) fifo_write({$urandom, $urandom});
    s_if.m_ready = 1'b1;
    enable = 1'b1;
    exp_total = ((5 + BL - 1) / BL) * BL;
    for (int c = 0; c < 40; c++) begin
      tick(1'b1, v, d, l, ed, el, r);
      if (beat_idx == 5) enable = 1'b0;
      if (v) begin
        checks++;
        if (d !== ed || l !== el) begin
          errors++;
          $display("FAIL drain_beat got %h last=%b expected %h last=%b", d, l, ed, el);
        end
      end
    end
    checks++;
    if (beat_idx != exp_total || s_if.m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_stop got %0d beats valid=%b busy=%b expected %0d beats valid=0 busy=0",
               beat_idx, s_if.m_valid, busy, exp_total);
    end
    checks++;
    if (wr_ptr - rd_ptr != 10 - exp_total) begin
      errors++;
      $display("FAIL drain_left got %0d words expected %0d", wr_ptr - rd_ptr, 10 - exp_total);
    end
`ifdef FIFO_BURST_READER_STATS_EN
    checks++;
    if (beat_count !== 32'(beat_idx) || burst_count !== 32'(beat_idx / BL)) begin
      errors++;
      $display("FAIL drain_stats got %0d/%0d expected %0d/%0d",
               beat_count, burst_count, beat_idx, beat_idx / BL);
    end
`endif
  endtask

  task automatic test_empty_gap();
    logic v, l, el, r;
    logic [W-1:0] d, ed;
    int lasts, c;
    do_reset();
    s_if.m_ready = 1'b1;
    enable = 1'b1;
    lasts = 0;
    for (int i = 0; i < 2; i++) fifo_write({$urandom, $urandom});
    for (int k = 0; k < 2; k++) begin
      c = 0;
      while (c < 20 && beat_idx < 2 * (k + 1)) begin
        tick(1'b1, v, d, l, ed, el, r);
        c++;
        if (v) begin
          checks++;
          if (d !== ed || l !== el) begin
            errors++;
            $display("FAIL gap_beat got %h last=%b expected %h last=%b", d, l, ed, el);
          end
          if (l) lasts++;
        end
      end
      if (k == 0) begin
        for (int g = 0; g < 5; g++) begin
          tick(1'b1, v, d, l, ed, el, r);
          checks++;
          if (v !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL gap_idle got valid=%b busy=%b expected valid=0 busy=1", v, busy);
          end
        end
        for (int i = 0; i < 2; i++) fifo_write({$urandom, $urandom});
      end
    end
    checks++;
    if (beat_idx != 4 || lasts != 1) begin
      errors++;
      $display("FAIL gap_burst got %0d beats %0d lasts expected 4 beats 1 last", beat_idx, lasts);
    end
  endtask

  task automatic test_reset_midburst();
    logic v, l, el, r;
    logic [W-1:0] d, ed;
    int c, lasts;
    do_reset();
    s_if.m_ready = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 2; i++) fifo_write({$urandom, $urandom});
    c = 0;
    while (c < 20 && beat_idx < 2) begin
      tick(1'b1, v, d, l, ed, el, r);
      c++;
    end
    for (int i = 0; i < 3; i++) fifo_write({$urandom, $urandom});
    v = 1'b0;
    c = 0;
    while (c < 10 && !v) begin
      tick(1'b0, v, d, l, ed, el, r);
      c++;
    end
    checks++;
    if (!v) begin
      errors++;
      $display("FAIL rst_setup got valid=0 expected valid=1 within 10 cycles");
    end
    do_reset();
    checks++;
    if ({s_if.m_valid, s_if.m_last, busy} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid got valid/last/busy=%b expected 000", {s_if.m_valid, s_if.m_last, busy});
    end
    tick(1'b0, v, d, l, ed, el, r);
    checks++;
    if (v !== 1'b0) begin
      errors++;
      $display("FAIL rst_inflight got valid=%b expected 0", v);
    end
`ifdef FIFO_BURST_READER_STATS_EN
    checks++;
    if (beat_count !== 32'd0 || burst_count !== 32'd0) begin
      errors++;
      $display("FAIL rst_stats got %0d/%0d expected 0/0", beat_count, burst_count);
    end
`endif
    for (int i = 0; i < BL; i++) fifo_write({$urandom, $urandom});
    enable = 1'b1;
    lasts = 0;
    c = 0;
    while (c < 30 && beat_idx < BL) begin
      tick(1'b1, v, d, l, ed, el, r);
      c++;
      if (v) begin
        checks++;
        if (d !== ed || l !== el) begin
          errors++;
          $display("FAIL rst_beat got %h last=%b expected %h last=%b", d, l, ed, el);
        end
        if (l) lasts++;
      end
    end
    checks++;
    if (beat_idx != BL || lasts != 1) begin
      errors++;
      $display("FAIL rst_burst got %0d beats %0d lasts expected %0d beats 1 last", beat_idx, lasts, BL);
    end
  endtask

  initial begin
    s_if.m_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_drain();
    test_empty_gap();
    test_reset_midburst();
    checks++;
    if (ren_empty_seen !== 1'b0) begin
      errors++;
      $display("FAIL ren_empty got fifo_ren while empty expected never");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side consumer stage placed directly downstream of the team's synchronous FIFO.
- Drives the FIFO's read enable and absorbs its one-cycle registered read latency.
- Re-emits words on a valid/ready stream, grouped into fixed-length bursts with a last marker.
- An enable/drain state machine guarantees bursts are never truncated when the consumer is switched off.

Parameters:
- WIDTH, 64: data word width; must match the upstream FIFO.
- BURST_LEN, 8: beats per burst; legal range 2..256, need not be a power of two.
- CNT_W, $clog2(BURST_LEN): localparam, beat counter width.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  level; 1 = stream bursts, 0 = finish the current burst then stop.
- fifo_empty  input  1  upstream FIFO empty flag.
- fifo_dout  input  WIDTH  upstream FIFO read data; valid the cycle after a read.
- fifo_ren  output  1  upstream FIFO read enable, combinational.
- m_data  output  WIDTH  stream data.
- m_valid  output  1  stream valid.
- m_last  output  1  high on the final beat of each burst.
- m_ready  input  1  stream ready from the downstream consumer.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (synchronous, active-high)
  - state=IDLE; buffer occupancy=0; in-flight flag=0; beat counter=0.
  - m_valid=0, m_last=0, m_data=0, busy=0.
  - fifo_ren=0 while reset is high.
- Output buffer
  - Two-entry FIFO of WIDTH bits; m_data/m_valid come from the head entry.
  - pop = m_valid && m_ready.
- Read issue
  - fifo_ren = !fifo_empty && permit && (occ + inflight - pop) < 2.
  - fifo_ren is never asserted while fifo_empty=1.
  - inflight is a 1-bit register, set to fifo_ren each cycle.
  - When inflight=1, fifo_dout is pushed into the buffer at the end of that cycle.
- Latency and throughput
  - fifo_ren in cycle N → m_valid with that word in cycle N+2.
  - With m_ready held at 1, sustains 1 beat/cycle.
  - Bubble-free under backpressure: no word is dropped or duplicated.
- Beat counter
  - Increments on pop; wraps to 0 after the pop where counter == BURST_LEN-1.
  - m_last = m_valid && (counter == BURST_LEN-1).
- State machine (IDLE, RUN, DRAIN)
  - IDLE: permit=0. Go to RUN when enable=1.
  - RUN: permit=1. If enable=0 and counter==0 and occ+inflight==0, go to IDLE. If enable=0 otherwise, go to DRAIN.
  - DRAIN: permit=1 only while occ + inflight < BURST_LEN - counter, i.e. only words needed to complete the burst are fetched. Go to IDLE on the pop carrying m_last. If enable returns to 1 before that, go to RUN.
- Boundary conditions
  - FIFO empty mid-burst: m_valid drops, the counter holds, and the burst resumes when data returns.
  - Simultaneous push and pop with occ=2: push is guaranteed not to occur, because the issue rule prevents it.
  - Simultaneous push and pop with occ=1: occ stays 1, head advances.
  - m_data/m_valid/m_last are held stable while m_valid && !m_ready.
  - Reset mid-burst: buffer contents, the in-flight word and burst position are discarded. The FIFO is reset on the same reset line.

Optional Feature:
- Macro: FIFO_BURST_READER_STATS_EN.
- When defined:
  - Adds output beat_count [31:0], incremented on each pop.
  - Adds output burst_count [31:0], incremented on each pop with m_last.
  - Both are 0 on reset and wrap at 2^32.
- When undefined: neither port nor the counters exist; all other behaviour is identical.

Test Plan:
- BURST_LEN=4; FIFO preloaded with 0x10..0x17; enable=1; m_ready=1 → fifo_ren first in cycle N, m_valid from N+2 for 8 consecutive cycles, data 0x10..0x17, m_last on 0x13 and 0x17.
- Same preload; m_ready toggling 1,0,0,1 repeatedly → all 8 words delivered in order, no loss or duplication, m_data stable while stalled, occupancy never exceeds 2.
- BURST_LEN=4; 10 words queued; enable dropped after 5 pops → DRAIN fetches exactly 3 more words, m_last on word 8, then IDLE with busy=0 and 2 words left in the FIFO.
- FIFO goes empty after 2 beats of a 4-beat burst for 5 cycles, then 2 more words written → m_valid low for the gap, the burst completes with m_last on beat 4.
- Reset asserted for 1 cycle with 1 word buffered and 1 in flight → next cycle m_valid=0, busy=0, counter=0; first beat after re-enable carries m_last only at position BURST_LEN-1.
- With FIFO_BURST_READER_STATS_EN: 3 full bursts at BURST_LEN=8 → beat_count=24, burst_count=3; reset → both 0.
